program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time stage directly upstream of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 18-bit instruction words.
- Writes those words sequentially into program RAM from address 0.
- Holds the CPU in reset until the image has been verified, then releases it via o_cpuRun.

Parameters:
- MAX_WORDS, 1024, largest legal word count N; headers with N > MAX_WORDS go to ERROR.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_byte  in  8  incoming stream byte.
- i_valid  in  1  i_byte is valid this cycle.
- o_ready  out  1  loader accepts i_byte this cycle; a transfer occurs when i_valid && o_ready.
- o_memAddr  out  16  program RAM write address.
- o_memData  out  18  program RAM write data.
- o_memWrite  out  1  single-cycle write strobe.
- o_cpuRun  out  1  1 = CPU released from reset.
- o_error  out  1  sticky load failure.
- o_wordCount  out  16  words written so far.

Behaviour:
- Reset (i_reset_n low at an edge), any state, including mid-load:
  - State goes to HDR_HI.
  - o_ready=0 during reset; o_memWrite=0, o_memAddr=0, o_memData=0, o_cpuRun=0, o_error=0, o_wordCount=0.
  - Checksum accumulator and N are cleared.
  - No partial word is ever written.
- Stream format:
  - 2-byte header N, MSB first.
  - N groups of 3 bytes per word:
    - B0[1:0] = instr bits 17:16, and B0[7:2] must be 0.
    - B1 = bits 15:8.
    - B2 = bits 7:0.
  - 1 checksum byte C.
  - C must equal the 8-bit modulo-256 sum of every preceding byte, header included.
- States: HDR_HI, HDR_LO, W0, W1, W2, WRITE, CHK, DONE, ERROR.
  - HDR_HI: on transfer, latch N[15:8] and go to HDR_LO.
  - HDR_LO: on transfer, latch N[7:0], then:
    - N > MAX_WORDS: go to ERROR.
    - N == 0: go to CHK.
    - Otherwise: go to W0.
  - W0: on transfer, go to ERROR if B0[7:2] != 0, else go to W1.
  - W1 and W2: on transfer, advance to the next state (W1 to W2, W2 to WRITE).
  - WRITE: lasts exactly one cycle with o_ready=0.
    - o_memWrite=1, o_memAddr=o_wordCount, o_memData=assembled word.
    - o_wordCount increments at the end of the cycle.
    - Next state is CHK if the new count == N, else W0.
  - CHK: on transfer, go to DONE if C matches, else ERROR. The checksum byte is not added to the sum.
  - DONE: o_cpuRun=1, o_ready=0. Terminal until reset.
  - ERROR: o_error=1, o_cpuRun=0, o_ready=0. Terminal until reset.
- Handshake:
  - o_ready=1 in HDR_HI, HDR_LO, W0, W1, W2, CHK; 0 elsewhere and during reset.
  - o_ready does not depend on i_valid.
  - i_valid=0 stalls the state machine with no side effects.
  - i_byte is ignored when no transfer occurs.
- Latency:
  - Write strobe is asserted the cycle after the B2 transfer.
  - o_cpuRun rises the cycle after a matching C transfer.
- Registered outputs:
  - All outputs are registered.
  - o_memAddr and o_memData hold their last values outside WRITE; only o_memWrite qualifies them.
- Arithmetic:
  - Checksum accumulates with 8-bit wrap.
  - o_wordCount never exceeds N, so no address wrap occurs; MAX_WORDS ≤ 65535.

Test Plan:
- Minimal image: bytes 00 01 | 02 34 56 | 8D, i_valid held high → one write, addr 0, data 18'h23456, 1 cycle after the 56 byte; o_cpuRun=1 one cycle after 8D; o_wordCount=1.
- Backpressure and stalls: 3-word image with i_valid toggled randomly → writes at addr 0,1,2 with correct data; o_ready=0 exactly in each WRITE cycle; no byte lost or duplicated.
- Empty image: 00 00 00 → DONE, no o_memWrite ever asserted. Stream 00 00 01 → ERROR, o_cpuRun stays 0.
- Format errors:
  - Header 04 01 (N=1025 > 1024) → ERROR after the second byte.
  - B0=0x04 in the first word → ERROR, no write issued.
- Reset mid-load: reset asserted after W1 of word 2 → all outputs zero; reloading the minimal image then succeeds with the write at addr 0.
- Checksum wrap: N=1 word FF-legalised as 03 FF FF; sum 00+01+03+FF+FF = 0x202, so C=0x02 → DONE, data 18'h3FFFF.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream into 18-bit words,
// writes them to program RAM from address 0 and releases the CPU once the image checks out.
module program_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_memAddr,
  output logic [17:0] o_memData,
  output logic        o_memWrite,
  output logic        o_cpuRun,
  output logic        o_error,
  output logic [15:0] o_wordCount
);

  // state  | meaning
  // HDR_HI | waiting for word-count high byte
  // HDR_LO | waiting for word-count low byte
  // W0     | waiting for instr bits 17:16 (upper six bits must be zero)
  // W1     | waiting for instr bits 15:8
  // W2     | waiting for instr bits 7:0
  // WRITE  | one-cycle RAM write, stream paused
  // CHK    | waiting for checksum byte
  // DONE   | image accepted, CPU running
  // ERROR  | load failed, CPU held in reset
  localparam logic [3:0] HDR_HI = 4'd0;
  localparam logic [3:0] HDR_LO = 4'd1;
  localparam logic [3:0] W0     = 4'd2;
  localparam logic [3:0] W1     = 4'd3;
  localparam logic [3:0] W2     = 4'd4;
  localparam logic [3:0] WRITE  = 4'd5;
  localparam logic [3:0] CHK    = 4'd6;
  localparam logic [3:0] DONE   = 4'd7;
  localparam logic [3:0] ERROR  = 4'd8;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  logic [3:0]  state;
  logic [3:0]  nextState;
  logic        nextReady;
  logic [7:0]  nHi;
  logic [15:0] nWords;
  logic [7:0]  checksum;
  logic [1:0]  wordHi;
  logic [7:0]  wordMid;
  logic [15:0] headerWord;
  logic        xfer;

  assign xfer       = i_valid && o_ready;
  assign headerWord = {nHi, i_byte};

  always_comb begin
    nextState = state;
    case (state)
      HDR_HI: if (xfer) nextState = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (headerWord > MAX_N)        nextState = ERROR;
          else if (headerWord == 16'd0)  nextState = CHK;
          else                           nextState = W0;
        end
      end
      W0:     if (xfer) nextState = (i_byte[7:2] != 6'd0) ? ERROR : W1;
      W1:     if (xfer) nextState = W2;
      W2:     if (xfer) nextState = WRITE;
      WRITE:  nextState = ((o_wordCount + 16'd1) == nWords) ? CHK : W0;
      CHK:    if (xfer) nextState = (i_byte == checksum) ? DONE : ERROR;
      DONE:   nextState = DONE;
      ERROR:  nextState = ERROR;
      default: nextState = ERROR;
    endcase
  end

  // Ready is registered from the next state so it is already low during the WRITE cycle.
  always_comb begin
    nextReady = nextState inside {HDR_HI, HDR_LO, W0, W1, W2, CHK};
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state       <= HDR_HI;
      o_ready     <= 1'b0;
      o_memAddr   <= 16'd0;
      o_memData   <= 18'd0;
      o_memWrite  <= 1'b0;
      o_cpuRun    <= 1'b0;
      o_error     <= 1'b0;
      o_wordCount <= 16'd0;
      nHi         <= 8'd0;
      nWords      <= 16'd0;
      checksum    <= 8'd0;
      wordHi      <= 2'd0;
      wordMid     <= 8'd0;
    end else begin
      state      <= nextState;
      o_ready    <= nextReady;
      o_memWrite <= 1'b0;
      o_cpuRun   <= (nextState == DONE);
      o_error    <= (nextState == ERROR);
      if (xfer && state != CHK) checksum <= checksum + i_byte;
      case (state)
        HDR_HI: if (xfer) nHi <= i_byte;
        HDR_LO: if (xfer) nWords <= headerWord;
        W0:     if (xfer) wordHi <= i_byte[1:0];
        W1:     if (xfer) wordMid <= i_byte;
        W2: begin
          if (xfer) begin
            o_memWrite <= 1'b1;
            o_memAddr  <= o_wordCount;
            o_memData  <= {wordHi, wordMid, i_byte};
          end
        end
        WRITE:  o_wordCount <= o_wordCount + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: fixed image table, hand sequences for reset/limits, and random
// images with random stalls checked against a stream-parsing reference model.
module tb_program_loader;

  typedef logic [7:0] byteQ_t[$];

  typedef struct {
    string       name;
    logic [7:0]  b[8];
    int          len;
    bit          expRun;
    bit          expErr;
    int          expCount;
    int          expWrites;
    logic [17:0] expLastData;
  } vec_t;

  logic        i_clock;
  logic        i_reset_n;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_memAddr;
  logic [17:0] o_memData;
  logic        o_memWrite;
  logic        o_cpuRun;
  logic        o_error;
  logic [15:0] o_wordCount;

  int checks = 0;
  int errors = 0;

  // reference model results
  int          mConsumed;
  bit          mRun;
  bit          mErr;
  int          mCount;
  int          mAddr[$];
  logic [17:0] mData[$];
  int          mB2[$];

  program_loader #(.MAX_WORDS(1024)) dut (
    .i_clock(i_clock),
    .i_reset_n(i_reset_n),
    .i_byte(i_byte),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_memAddr(o_memAddr),
    .o_memData(o_memData),
    .o_memWrite(o_memWrite),
    .o_cpuRun(o_cpuRun),
    .o_error(o_error),
    .o_wordCount(o_wordCount)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Parses the stream by its format rules: header, N words, checksum over all prior bytes.
  task automatic modelImage(input byteQ_t b);
    int n;
    int total;
    logic [7:0] b0;
    mAddr.delete(); mData.delete(); mB2.delete();
    mRun = 0; mErr = 0; mCount = 0;
    n = int'({b[0], b[1]});
    total = int'(b[0]) + int'(b[1]);
    if (n > 1024) begin
      mErr = 1; mConsumed = 2;
      return;
    end
    for (int w = 0; w < n; w++) begin
      int p;
      p = 2 + 3 * w;
      b0 = b[p];
      if (b0 > 8'd3) begin
        mErr = 1; mConsumed = p + 1;
        return;
      end
      mAddr.push_back(w);
      mData.push_back({b0[1:0], b[p+1], b[p+2]});
      mB2.push_back(p + 2);
      mCount = w + 1;
      total += int'(b[p]) + int'(b[p+1]) + int'(b[p+2]);
    end
    mConsumed = 3 + 3 * n;
    if (b[2 + 3 * n] == 8'(total)) mRun = 1;
    else mErr = 1;
  endtask

  function automatic byteQ_t genImage(input int n, input bit badB0, input bit badChk);
    byteQ_t q;
    int total;
    int badW;
    logic [7:0] b0;
    total = 0;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    badW = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
    if (n <= 1024) begin
      for (int w = 0; w < n; w++) begin
        b0 = 8'($urandom_range(0, 3));
        if (badB0 && w == badW) b0 = 8'($urandom_range(4, 255));
        q.push_back(b0);
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
      end
    end
    foreach (q[i]) total += int'(q[i]);
    q.push_back(8'(total) + (badChk ? 8'($urandom_range(1, 255)) : 8'd0));
    return q;
  endfunction

  task automatic applyReset();
    @(negedge i_clock);
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_byte    = 8'($urandom);
    @(negedge i_clock);
    @(negedge i_clock);
    chk("rst/ready", 32'(o_ready), 0);
    chk("rst/memWrite", 32'(o_memWrite), 0);
    chk("rst/memAddr", 32'(o_memAddr), 0);
    chk("rst/memData", 32'(o_memData), 0);
    chk("rst/cpuRun", 32'(o_cpuRun), 0);
    chk("rst/error", 32'(o_error), 0);
    chk("rst/wordCount", 32'(o_wordCount), 0);
    i_reset_n = 1'b1;
  endtask

  // stopAfter < 0 runs the image to its end; otherwise stops feeding after that many bytes.
  task automatic runImage(input byteQ_t b, input int validPct, input int stopAfter,
                          output int nWrites, output logic [17:0] lastData);
    int  idx = 0;
    int  lastXfer = -1;
    int  budget = 0;
    int  drain = 0;
    int  wi = 0;
    int  extra = 0;
    int  limit;
    bit  started = 0;
    bit  v;
    nWrites  = 0;
    lastData = 18'd0;
    modelImage(b);
    limit = (stopAfter >= 0) ? stopAfter : mConsumed;
    while (drain < 4) begin
      @(negedge i_clock);
      budget++;
      if (budget > 20000) begin
        checks++; errors++;
        $display("FAIL timeout accepted=%0d required=%0d", idx, limit);
        break;
      end
      if (o_memWrite) begin
        nWrites++;
        lastData = o_memData;
        chk("write/ready", 32'(o_ready), 0);
        if (wi < mAddr.size()) begin
          chk("write/addr", 32'(o_memAddr), 32'(mAddr[wi]));
          chk("write/data", 32'(o_memData), 32'(mData[wi]));
          chk("write/latency", 32'(lastXfer), 32'(mB2[wi]));
          wi++;
        end else begin
          checks++; errors++;
          $display("FAIL extraWrite actual=%0d required=%0d", nWrites, mAddr.size());
        end
      end
      if (o_ready) started = 1;
      if (started && idx < limit && !o_memWrite) chk("load/ready", 32'(o_ready), 1);
      if (idx < limit) begin
        chk("load/cpuRun", 32'(o_cpuRun), 0);
        chk("load/error", 32'(o_error), 0);
      end
      if (stopAfter < 0 && lastXfer == mConsumed - 1) begin
        chk("final/cpuRunLatency", 32'(o_cpuRun), 32'(mRun));
        chk("final/errorLatency", 32'(o_error), 32'(mErr));
      end
      lastXfer = -1;
      if (idx < limit) begin
        v = ($urandom_range(1, 100) <= validPct);
        i_valid = v;
        i_byte  = v ? b[idx] : 8'($urandom);
      end else begin
        drain++;
        i_valid = (stopAfter < 0);
        i_byte  = 8'($urandom);
      end
      if (i_valid && o_ready) begin
        if (idx < limit) begin
          lastXfer = idx;
          idx++;
        end else extra++;
      end
    end
    i_valid = 1'b0;
    if (stopAfter < 0) begin
      chk("final/extraBytes", 32'(extra), 0);
      chk("final/writes", 32'(wi), 32'(mAddr.size()));
      chk("final/wordCount", 32'(o_wordCount), 32'(mCount));
      chk("final/cpuRun", 32'(o_cpuRun), 32'(mRun));
      chk("final/error", 32'(o_error), 32'(mErr));
      chk("final/ready", 32'(o_ready), 0);
    end
  endtask

  vec_t        vecs[7];
  byteQ_t      q;
  int          nw;
  logic [17:0] ld;

  initial begin
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_byte    = 8'd0;

    vecs[0] = '{"minimal",   '{8'h00,8'h01,8'h02,8'h34,8'h56,8'h8D,8'h00,8'h00}, 6, 1, 0, 1, 1, 18'h23456};
    vecs[1] = '{"empty",     '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 1, 0, 0, 0, 18'h0};
    vecs[2] = '{"emptyBad",  '{8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 1, 0, 0, 18'h0};
    vecs[3] = '{"tooLong",   '{8'h04,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1, 0, 0, 18'h0};
    vecs[4] = '{"badB0",     '{8'h00,8'h01,8'h04,8'h34,8'h56,8'h8D,8'h00,8'h00}, 6, 0, 1, 0, 0, 18'h0};
    vecs[5] = '{"wrap",      '{8'h00,8'h01,8'h03,8'hFF,8'hFF,8'h02,8'h00,8'h00}, 6, 1, 0, 1, 1, 18'h3FFFF};
    vecs[6] = '{"badChk",    '{8'h00,8'h01,8'h02,8'h34,8'h56,8'h8C,8'h00,8'h00}, 6, 0, 1, 1, 1, 18'h23456};

    applyReset();

    for (int i = 0; i < 7; i++) begin
      applyReset();
      q.delete();
      for (int k = 0; k < vecs[i].len; k++) q.push_back(vecs[i].b[k]);
      runImage(q, 100, -1, nw, ld);
      chk({vecs[i].name, "/writes"}, 32'(nw), 32'(vecs[i].expWrites));
      chk({vecs[i].name, "/lastData"}, 32'(ld), 32'(vecs[i].expLastData));
      chk({vecs[i].name, "/cpuRun"}, 32'(o_cpuRun), 32'(vecs[i].expRun));
      chk({vecs[i].name, "/error"}, 32'(o_error), 32'(vecs[i].expErr));
      chk({vecs[i].name, "/wordCount"}, 32'(o_wordCount), 32'(vecs[i].expCount));
    end

    // two-word image: 0x11122, 0x33344, checksum 0xB0
    applyReset();
    q = '{8'h00, 8'h02, 8'h01, 8'h11, 8'h22, 8'h03, 8'h33, 8'h44, 8'hB0};
    runImage(q, 45, -1, nw, ld);
    chk("twoWord/writes", 32'(nw), 2);
    chk("twoWord/lastData", 32'(ld), 32'h33344);

    // three words with heavy stalling
    applyReset();
    q = genImage(3, 0, 0);
    runImage(q, 40, -1, nw, ld);
    chk("stall3/writes", 32'(nw), 3);
    chk("stall3/cpuRun", 32'(o_cpuRun), 1);

    // reset after the second byte of word 2, then a clean reload
    applyReset();
    q = '{8'h00, 8'h02, 8'h01, 8'h11, 8'h22, 8'h03, 8'h33, 8'h44, 8'hB0};
    runImage(q, 100, 7, nw, ld);
    chk("midLoad/writesBeforeReset", 32'(nw), 1);
    applyReset();
    q = '{8'h00, 8'h01, 8'h02, 8'h34, 8'h56, 8'h8D};
    runImage(q, 100, -1, nw, ld);
    chk("reload/writes", 32'(nw), 1);
    chk("reload/data", 32'(ld), 32'h23456);
    chk("reload/cpuRun", 32'(o_cpuRun), 1);

    // largest legal image
    applyReset();
    q = genImage(1024, 0, 0);
    runImage(q, 100, -1, nw, ld);
    chk("max/writes", 32'(nw), 1024);
    chk("max/wordCount", 32'(o_wordCount), 1024);

    for (int t = 0; t < 25; t++) begin
      int n;
      bit bb;
      bit bc;
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1025, 1100)) : int'($urandom_range(0, 6));
      bb = ($urandom_range(0, 4) == 0);
      bc = ($urandom_range(0, 4) == 0);
      applyReset();
      q = genImage(n, bb, bc);
      runImage(q, int'($urandom_range(30, 100)), -1, nw, ld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
